// File: rtl/fc_pkg.sv
// Shared constants and element type for the fully-connected input path.
package fc_pkg;

  // Elements per frame (flattened feature map length).
  localparam int FC_IN    = 400;

  // Element width in bits.
  localparam int FC_WIDTH = 8;

  typedef logic [FC_WIDTH-1:0] elem_t;

  // Index width needed to address one frame of n elements.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_bank.sv
// One frame-sized register bank: single write port, full parallel read.
// Contents clear on reset so a dropped frame never leaks to the consumer.
module fc_bank
  import fc_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int DEPTH = FC_IN,
  localparam int IW   = idx_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata [0:DEPTH-1]
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  // Storage: clear everything on reset, otherwise write one entry per enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Every entry is visible at once for the downstream layer.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_rdata[k] = r_mem[k];
    end
  end

endmodule

// File: rtl/fc_input_buffer.sv
// Ping-pong frame collector: serial element stream in, parallel frame out.
//
// Handshake: an input element transfers on a rising edge where s_valid and
// s_ready are both high; s_ready depends only on registered state and never
// on s_valid or x_ack. A frame is consumed on a rising edge where x_valid and
// x_ack are both high; x_ack with x_valid low has no effect.
module fc_input_buffer
  import fc_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int IN    = FC_IN,
  localparam int IW   = idx_bits(IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ack,
  output logic             err_len
);

  localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);

  // Pointer and occupancy state.
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_wr_idx;
  logic          r_err_len;

  // Derived strobes.
  logic          w_accept;
  logic          w_at_end;
  logic          w_commit;
  logic          w_consume;
  logic          w_len_err;
  logic [1:0]    w_full_nxt;
  logic          w_we0;
  logic          w_we1;

  logic [WIDTH-1:0] w_rd0 [0:IN-1];
  logic [WIDTH-1:0] w_rd1 [0:IN-1];

  // Handshake and length-check strobes from registered state and inputs.
  always_comb begin
    s_ready   = !r_full[r_wr_bank];
    x_valid   = r_full[r_rd_bank];
    w_accept  = s_valid && s_ready;
    w_at_end  = (r_wr_idx == LAST_IDX);
    // Reaching the last slot commits the frame whether or not s_last came.
    w_commit  = w_accept && w_at_end;
    w_consume = x_valid && x_ack;
    // Early last (discard) and missing last (commit anyway) are both errors.
    w_len_err = w_accept && (w_at_end ? !s_last : s_last);
    w_we0     = w_accept && !r_wr_bank;
    w_we1     = w_accept &&  r_wr_bank;
  end

  // Next occupancy: commit and consume always hit different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_consume) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  // Write pointer: advance, wrap on a committed frame, restart on early last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_accept) begin
      if (w_at_end) begin
        r_wr_idx  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (s_last) begin
        r_wr_idx  <= '0;
      end else begin
        r_wr_idx  <= r_wr_idx + IW'(1);
      end
    end
  end

  // Read pointer advances on each consumed frame, keeping arrival order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank <= 1'b0;
    end else if (w_consume) begin
      r_rd_bank <= ~r_rd_bank;
    end
  end

  // Occupancy flags and the one-cycle length error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_err_len <= 1'b0;
    end else begin
      r_full    <= w_full_nxt;
      r_err_len <= w_len_err;
    end
  end

  assign err_len = r_err_len;

  fc_bank #(
    .WIDTH (WIDTH),
    .DEPTH (IN)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we0),
    .i_waddr (r_wr_idx),
    .i_wdata (s_data),
    .o_rdata (w_rd0)
  );

  fc_bank #(
    .WIDTH (WIDTH),
    .DEPTH (IN)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we1),
    .i_waddr (r_wr_idx),
    .i_wdata (s_data),
    .o_rdata (w_rd1)
  );

  // Output mux: present the bank the read pointer selects.
  always_comb begin
    for (int k = 0; k < IN; k++) begin
      x[k] = r_rd_bank ? w_rd1[k] : w_rd0[k];
    end
  end

endmodule

// File: tb/tb_fc_input_buffer.sv
// Directed bench for fc_input_buffer.
module tb_fc_input_buffer;
  import fc_pkg::*;

  localparam int W = FC_WIDTH;
  localparam int N = FC_IN;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [W-1:0] x [0:N-1];
  logic         x_valid;
  logic         x_ack;
  logic         err_len;

  always #5 clk = ~clk;

  fc_input_buffer #(
    .WIDTH (W),
    .IN    (N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .x       (x),
    .x_valid (x_valid),
    .x_ack   (x_ack),
    .err_len (err_len)
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  int           stall_cycles = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pattern generator: 0 = (k+seed) mod 256, 1 = constant seed, 2 = 255-k mod 256.
  function automatic logic [W-1:0] exp_elem(input int mode, input int seed, input int k);
    case (mode)
      0:       return W'((k + seed) % 256);
      1:       return W'(seed);
      default: return W'((255 - k) & 255);
    endcase
  endfunction

  // Number of positions where the presented frame differs from the pattern.
  function automatic int frame_bad(input int mode, input int seed);
    int cnt = 0;
    for (int k = 0; k < N; k++) begin
      if (x[k] !== exp_elem(mode, seed, k)) cnt++;
    end
    return cnt;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one element; waits (bounded) for s_ready, leaves s_valid high.
  task automatic send_elem(input logic [W-1:0] d, input logic last);
    int b = 0;
    while (!s_ready && b < 2000) begin
      s_valid = 1'b0;
      tick();
      b++;
      stall_cycles++;
    end
    if (b >= 2000) check("ready_timeout", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
  endtask

  // Send len elements; s_last only at index last_idx (-1 for none).
  task automatic send_frame(input int mode, input int seed, input int len, input int last_idx);
    for (int i = 0; i < len; i++) begin
      send_elem(exp_elem(mode, seed, i), (i == last_idx));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic ack_once();
    x_ack = 1'b1;
    tick();
    x_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bubbles;
    int windows;
    int long_win;
    logic prev_v;
    logic [W-1:0] seed;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    x_ack   = 1'b0;
    #22;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_x_valid", {31'd0, x_valid}, 32'd0);
    check("rst_err_len", {31'd0, err_len}, 32'd0);
    check("rst_x_zero", frame_bad(1, 0), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame 1: value k mod 256, last on 399, no ack.
    stall_cycles = 0;
    for (int i = 0; i < N - 1; i++) send_elem(exp_elem(0, 0, i), 1'b0);
    check("f1_not_early", {31'd0, x_valid}, 32'd0);
    send_elem(exp_elem(0, 0, N - 1), 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("f1_x_valid", {31'd0, x_valid}, 32'd1);
    check("f1_data", frame_bad(0, 0), 32'd0);
    check("f1_x5", {24'd0, x[5]}, 32'd5);
    check("f1_x300", {24'd0, x[300]}, 32'd44);
    check("f1_ready_high", {31'd0, s_ready}, 32'd1);
    check("f1_no_stall", stall_cycles, 32'd0);
    check("f1_err_len", {31'd0, err_len}, 32'd0);

    // Frame 2 all 0xAA, still no ack: both banks full.
    send_frame(1, 'hAA, N, N - 1);
    check("f2_ready_low", {31'd0, s_ready}, 32'd0);
    check("f2_x_still_f1", frame_bad(0, 0), 32'd0);
    // Frame 3 attempt is held off.
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (3) tick();
    check("f3_blocked_ready", {31'd0, s_ready}, 32'd0);
    check("f3_blocked_x", frame_bad(0, 0), 32'd0);
    s_valid = 1'b0;

    // Ack frame 1: frame 2 appears and s_ready rises after the ack edge.
    ack_once();
    check("ack_x_aa", frame_bad(1, 'hAA), 32'd0);
    check("ack_x_valid", {31'd0, x_valid}, 32'd1);
    check("ack_ready_up", {31'd0, s_ready}, 32'd1);
    ack_once();
    check("ack2_x_valid", {31'd0, x_valid}, 32'd0);

    // Early last at index 149: discarded, one-cycle error.
    send_frame(0, 100, 150, 149);
    check("early_err_len", {31'd0, err_len}, 32'd1);
    check("early_no_valid", {31'd0, x_valid}, 32'd0);
    tick();
    check("early_err_drop", {31'd0, err_len}, 32'd0);
    send_frame(2, 0, N, N - 1);
    check("after_early_valid", {31'd0, x_valid}, 32'd1);
    check("after_early_data", frame_bad(2, 0), 32'd0);
    check("after_early_err", {31'd0, err_len}, 32'd0);
    ack_once();

    // Missing last: committed anyway with an error pulse.
    send_frame(0, 33, N, -1);
    check("miss_valid", {31'd0, x_valid}, 32'd1);
    check("miss_err_len", {31'd0, err_len}, 32'd1);
    check("miss_data", frame_bad(0, 33), 32'd0);
    tick();
    check("miss_err_drop", {31'd0, err_len}, 32'd0);
    check("miss_still_valid", {31'd0, x_valid}, 32'd1);
    ack_once();

    // Reset at index 200 with one frame held.
    send_frame(1, 'h3C, N, N - 1);
    send_frame(0, 9, 200, -1);
    rst_n = 1'b0;
    #1;
    check("midrst_x_valid", {31'd0, x_valid}, 32'd0);
    check("midrst_x_zero", frame_bad(1, 0), 32'd0);
    check("midrst_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(0, 77, N, N - 1);
    check("postrst_valid", {31'd0, x_valid}, 32'd1);
    check("postrst_data", frame_bad(0, 77), 32'd0);
    check("postrst_err", {31'd0, err_len}, 32'd0);
    ack_once();

    // Continuous streaming with x_ack held high.
    x_ack    = 1'b1;
    bubbles  = 0;
    windows  = 0;
    long_win = 0;
    prev_v   = 1'b0;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_ready) bubbles++;
        s_valid = 1'b1;
        s_data  = exp_elem(0, f * 7, i);
        s_last  = (i == N - 1);
        if (i == N - 1) exp_q.push_back(W'(f * 7));
        tick();
        if (x_valid) begin
          windows++;
          if (prev_v) long_win++;
          if (exp_q.size() == 0) begin
            check("cont_extra_frame", 32'd1, 32'd0);
          end else begin
            seed = exp_q.pop_front();
            check("cont_frame", frame_bad(0, int'(seed)), 32'd0);
          end
        end
        prev_v = x_valid;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    check("cont_drained", {31'd0, x_valid}, 32'd0);
    check("cont_windows", windows, 32'd10);
    check("cont_one_cycle", long_win, 32'd0);
    check("cont_bubbles", bubbles, 32'd0);
    check("cont_queue_empty", exp_q.size(), 32'd0);
    x_ack = 1'b0;

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
